// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared encodings for the RV32I writeback stage (result source,
//           load funct3 codes, writeback FSM states).
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/riscv_wb_stage_if.sv
// ============================================================================
// Module  : riscv_wb_stage_if
// Brief   : MEM -> WB retirement handshake and instruction payload.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface riscv_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_reg_write;
  logic [4:0]      in_rd;
  logic [1:0]      in_result_src;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic [2:0]      in_funct3;

  modport master (
    output in_valid, in_reg_write, in_rd, in_result_src,
           in_alu_result, in_pc_plus4, in_funct3,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_result_src,
           in_alu_result, in_pc_plus4, in_funct3,
    output in_ready
  );
endinterface

`default_nettype wire

// File: rtl/riscv_load_align.sv
// ============================================================================
// Module  : riscv_load_align
// Brief   : Combinational load extraction: selects byte/half/word from the raw
//           memory word by address LSBs and sign- or zero-extends it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    // Halfword select ignores addr_lo[0]: misaligned halves are not trapped here
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_wb_stage.sv
// ============================================================================
// Module  : riscv_wb_stage
// Brief   : RV32I writeback stage: one-entry holding buffer, load-wait FSM,
//           registered register-file write port, sticky spurious-rvalid flag.
//           Optional retired-instruction counter under RISCV_WB_INSTRET_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
`ifdef RISCV_WB_INSTRET_EN
  , parameter int INSTRET_W = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  riscv_wb_stage_if.slave  mem,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [XLEN-1:0]  wd3,
  output logic             dmem_spurious
`ifdef RISCV_WB_INSTRET_EN
  , output logic [INSTRET_W-1:0] instret
`endif
);

  wb_state_e       state_q, state_d;
  logic            we3_q, we3_d;
  logic [4:0]      wa3_q, wa3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            spurious_q, spurious_d;

  // Holding buffer for the instruction in flight
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;

  logic            accept;
  logic [XLEN-1:0] direct_result;
  logic [XLEN-1:0] load_data;

  riscv_load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .rdata   (dmem_rdata),
    .data    (load_data)
  );

  assign mem.in_ready = (state_q != ST_WAIT_LOAD);
  assign accept       = mem.in_valid & mem.in_ready;

  always_comb begin
    case (mem.in_result_src)
      RESULT_PC4: direct_result = mem.in_pc_plus4;
      RESULT_ALU: direct_result = mem.in_alu_result;
      default:    direct_result = mem.in_alu_result;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we3_d       = 1'b0;
    wa3_d       = wa3_q;
    wd3_d       = wd3_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    spurious_d  = spurious_q | (dmem_rvalid & (state_q != ST_WAIT_LOAD));

    case (state_q)
      ST_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = ST_WRITE;
          if (reg_write_q && (rd_q != 5'd0)) begin
            we3_d = 1'b1;
            wa3_d = rd_q;
            wd3_d = load_data;
          end
        end
      end
      default: begin
        if (accept) begin
          reg_write_d = mem.in_reg_write;
          rd_d        = mem.in_rd;
          funct3_d    = mem.in_funct3;
          addr_lo_d   = mem.in_alu_result[1:0];
          if (mem.in_result_src == RESULT_LOAD) begin
            state_d = ST_WAIT_LOAD;
          end else begin
            state_d = ST_WRITE;
            if (mem.in_reg_write && (mem.in_rd != 5'd0)) begin
              we3_d = 1'b1;
              wa3_d = mem.in_rd;
              wd3_d = direct_result;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we3_q       <= 1'b0;
      wa3_q       <= 5'd0;
      wd3_q       <= '0;
      spurious_q  <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      we3_q       <= we3_d;
      wa3_q       <= wa3_d;
      wd3_q       <= wd3_d;
      spurious_q  <= spurious_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  assign we3           = we3_q;
  assign wa3           = wa3_q;
  assign wd3           = wd3_q;
  assign dmem_spurious = spurious_q;

`ifdef RISCV_WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q, instret_d;

  // Every WRITE cycle retires one instruction, including rd=x0 and no-write ops
  always_comb begin
    instret_d = instret_q;
    if (state_q == ST_WRITE) begin
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_wb_stage.sv
// ============================================================================
// Module  : tb_riscv_wb_stage
// Brief   : Self-checking bench for riscv_wb_stage: directed cases plus random
//           instruction mix against a transaction-level writeback model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscv_wb_stage;

  logic        clk;
  logic        rst;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        dmem_spurious;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0]  exp_wa = 5'd0;
  logic [31:0] exp_wd = 32'd0;

  riscv_wb_stage_if #(.XLEN(32)) mem_if ();

  riscv_wb_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mem_if),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .we3           (we3),
    .wa3           (wa3),
    .wd3           (wd3),
    .dmem_spurious (dmem_spurious)
`ifdef RISCV_WB_INSTRET_EN
    , .instret     (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction, from plain shift/mask arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Issue one instruction, complete it, and check the resulting write port
  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                      input int delay, input logic [31:0] rdata);
    logic [31:0] val;
    logic        exp_we;
    check("ready_before_accept", mem_if.in_ready, 1'b1);
    mem_if.in_valid      = 1'b1;
    mem_if.in_reg_write  = rw;
    mem_if.in_rd         = rd;
    mem_if.in_result_src = src;
    mem_if.in_alu_result = alu;
    mem_if.in_pc_plus4   = pc4;
    mem_if.in_funct3     = f3;
    tick();
    mem_if.in_valid = 1'b0;
    if (src == 2'b01) begin
      for (int i = 0; i < delay; i++) begin
        check("ready_low_waiting", mem_if.in_ready, 1'b0);
        check("we3_low_waiting", we3, 1'b0);
        tick();
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      tick();
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      val = ref_load(f3, alu[1:0], rdata);
    end else if (src == 2'b10) begin
      val = pc4;
    end else begin
      val = alu;
    end
    exp_we = rw && (rd != 5'd0);
    if (exp_we) begin
      exp_wa = rd;
      exp_wd = val;
    end
    check("we3", we3, exp_we);
    check("wa3", wa3, exp_wa);
    check("wd3", wd3, exp_wd);
  endtask

  initial begin
    rst                  = 1'b1;
    dmem_rvalid          = 1'b0;
    dmem_rdata           = 32'd0;
    mem_if.in_valid      = 1'b0;
    mem_if.in_reg_write  = 1'b0;
    mem_if.in_rd         = 5'd0;
    mem_if.in_result_src = 2'b00;
    mem_if.in_alu_result = 32'd0;
    mem_if.in_pc_plus4   = 32'd0;
    mem_if.in_funct3     = 3'd0;
    #12;
    check("rst_we3", we3, 1'b0);
    check("rst_wa3", wa3, 5'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_spurious", dmem_spurious, 1'b0);
    check("rst_ready", mem_if.in_ready, 1'b1);
`ifdef RISCV_WB_INSTRET_EN
    check("rst_instret", instret, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Back-to-back ALU ops on rd=1,2,3
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, 5'(i), 2'b00, $urandom, $urandom, 3'd0, 0, 32'd0);
    end
    tick();
    check("b2b_we3_drop", we3, 1'b0);
`ifdef RISCV_WB_INSTRET_EN
    check("instret_after_b2b", instret, 64'd3);
`endif

    // Plain ALU op
    send(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 0, 32'd0);
    check("alu_wd3_value", wd3, 32'h1234_5678);
    tick();

    // rd=x0 never writes; wa3/wd3 must hold
    send(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 32'h0, 3'd0, 0, 32'd0);
    check("x0_wd3_hold", wd3, 32'h1234_5678);
    tick();

    // LB from byte 3, rvalid four cycles late
    send(1'b1, 5'd7, 2'b01, 32'h0000_1003, 32'h0, 3'b000, 4, 32'h80AA_BBCC);
    check("lb_value", wd3, 32'hFFFF_FF80);
    // LHU then LH on upper half
    send(1'b1, 5'd8, 2'b01, 32'h0000_2002, 32'h0, 3'b101, 1, 32'h8001_0000);
    check("lhu_value", wd3, 32'h0000_8001);
    send(1'b1, 5'd9, 2'b01, 32'h0000_2002, 32'h0, 3'b001, 0, 32'h8001_0000);
    check("lh_value", wd3, 32'hFFFF_8001);
    // Link value
    send(1'b1, 5'd1, 2'b10, 32'hDEAD_0000, 32'h0000_0104, 3'd0, 0, 32'd0);
    tick();

    // Random instruction mix
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rd;
      rd = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
      send(($urandom % 4) != 0, rd, 2'($urandom), $urandom, $urandom, 3'($urandom),
           int'($urandom % 4), $urandom);
      if ($urandom % 3 == 0) begin
        tick();
        check("gap_we3", we3, 1'b0);
      end
    end
    check("no_spurious", dmem_spurious, 1'b0);

    // Reset while a load is outstanding, then its late rvalid
    check("pre_rst_ready", mem_if.in_ready, 1'b1);
    mem_if.in_valid      = 1'b1;
    mem_if.in_reg_write  = 1'b1;
    mem_if.in_rd         = 5'd10;
    mem_if.in_result_src = 2'b01;
    mem_if.in_alu_result = 32'h0000_0040;
    mem_if.in_funct3     = 3'b010;
    tick();
    mem_if.in_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_waiting", mem_if.in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_we3", we3, 1'b0);
    check("async_rst_wd3", wd3, 32'd0);
    check("async_rst_ready", mem_if.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    check("late_rvalid_we3", we3, 1'b0);
    check("late_rvalid_wd3", wd3, 32'd0);
    check("late_rvalid_spurious", dmem_spurious, 1'b1);
    tick();
    check("spurious_sticky", dmem_spurious, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
